// File: rtl/usb_tx_fifo_pkg.sv
// Shared constants for the USB transmit FIFO: register map, status bit
// positions and default geometry.
package usb_tx_fifo_pkg;

    localparam int TXF_FIFO_DEPTH = 64;
    localparam int TXF_ADDR_WIDTH = 6;

    localparam logic [2:0] TXF_ADDR_DATA    = 3'd0;
    localparam logic [2:0] TXF_ADDR_STATUS  = 3'd1;
    localparam logic [2:0] TXF_ADDR_CTRL    = 3'd2;
    localparam logic [2:0] TXF_ADDR_CNT_MSB = 3'd3;
    localparam logic [2:0] TXF_ADDR_CNT_LSB = 3'd4;

    localparam int TXF_STAT_EMPTY_BIT = 0;
    localparam int TXF_STAT_FULL_BIT  = 1;
    localparam int TXF_STAT_OVF_BIT   = 2;

    localparam int TXF_CTRL_FORCE_EMPTY_BIT = 0;

endpackage

// File: rtl/usb_tx_fifo_if.sv
// Bus register port plus SIE pop port of the transmit FIFO, bundled so the
// host/SIE side (master) and the FIFO (slave) share one connection.
interface usb_tx_fifo_if;
    logic [2:0]  busAddress;
    logic        busWriteEn;
    logic        busStrobe_i;
    logic        busFifoSelect;
    logic [7:0]  busDataIn;
    logic [7:0]  busDataOut;
    logic        fifoREn;
    logic [7:0]  fifoDataOut;
    logic        fifoEmpty;
    logic        fifoFull;
    logic [15:0] numElementsInFifo;

    // An access happens in exactly the cycle where busFifoSelect and busStrobe_i
    // are both high; there is no back-pressure. A pop happens when fifoREn is high
    // and fifoEmpty is low in the same cycle; fifoDataOut is the byte being popped.
    modport master (
        output busAddress, busWriteEn, busStrobe_i, busFifoSelect, busDataIn, fifoREn,
        input  busDataOut, fifoDataOut, fifoEmpty, fifoFull, numElementsInFifo
    );

    modport slave (
        input  busAddress, busWriteEn, busStrobe_i, busFifoSelect, busDataIn, fifoREn,
        output busDataOut, fifoDataOut, fifoEmpty, fifoFull, numElementsInFifo
    );
endinterface

// File: rtl/usb_tx_fifo_bi.sv
// Bus-side register decode: produces push/forceEmpty strobes and the registered
// read-back data for the status and occupancy registers.
module usb_tx_fifo_bi
    import usb_tx_fifo_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  addr_i,
    input  logic        we_i,
    input  logic        strobe_i,
    input  logic        sel_i,
    input  logic [7:0]  data_i,
    input  logic        empty_i,
    input  logic        full_i,
    input  logic        overflow_i,
    input  logic [15:0] count_i,
    output logic        push_o,
    output logic        force_empty_o,
    output logic [7:0]  data_o
);

    logic       acc;
    logic [7:0] rd_data;
    logic [7:0] data_d;
    logic [7:0] data_q;

    assign acc           = sel_i & strobe_i;
    assign push_o        = acc & we_i & (addr_i == TXF_ADDR_DATA);
    assign force_empty_o = acc & we_i & (addr_i == TXF_ADDR_CTRL) & data_i[TXF_CTRL_FORCE_EMPTY_BIT];

    always_comb begin
        rd_data = 8'h00;
        case (addr_i)
            TXF_ADDR_STATUS: begin
                rd_data[TXF_STAT_EMPTY_BIT] = empty_i;
                rd_data[TXF_STAT_FULL_BIT]  = full_i;
                rd_data[TXF_STAT_OVF_BIT]   = overflow_i;
            end
            TXF_ADDR_CNT_MSB: rd_data = count_i[15:8];
            TXF_ADDR_CNT_LSB: rd_data = count_i[7:0];
            default:          rd_data = 8'h00;
        endcase
    end

    // Read data is captured in the strobe cycle and held until the next read.
    assign data_d = (acc & ~we_i) ? rd_data : data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) data_q <= 8'h00;
        else          data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/usb_tx_fifo.sv
// Transmit-direction endpoint FIFO: bus pushes bytes, the SIE pops them from a
// show-ahead head. Single clock, so pointers and count live in one domain.
module usb_tx_fifo
    import usb_tx_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = TXF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = TXF_ADDR_WIDTH
) (
    input  logic          usbClk,
    input  logic          rstN,
    usb_tx_fifo_if.slave  bus
);

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic push_req, force_empty, push_ok, pop_ok, full, empty;

    assign full    = (count_q == (ADDR_WIDTH+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_req & ~full;
    assign pop_ok  = bus.fifoREn & ~empty;

    usb_tx_fifo_bi u_bi (
        .clk_i         (usbClk),
        .rst_n_i       (rstN),
        .addr_i        (bus.busAddress),
        .we_i          (bus.busWriteEn),
        .strobe_i      (bus.busStrobe_i),
        .sel_i         (bus.busFifoSelect),
        .data_i        (bus.busDataIn),
        .empty_i       (empty),
        .full_i        (full),
        .overflow_i    (overflow_q),
        .count_i       (16'(count_q)),
        .push_o        (push_req),
        .force_empty_o (force_empty),
        .data_o        (bus.busDataOut)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (force_empty) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            if (push_ok && !pop_ok)      count_d = count_q + (ADDR_WIDTH+1)'(1);
            else if (pop_ok && !push_ok) count_d = count_q - (ADDR_WIDTH+1)'(1);
            // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
            if (push_req && full) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge usbClk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge usbClk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.busDataIn;
    end

    assign bus.fifoDataOut       = mem_q[rd_ptr_q];
    assign bus.fifoEmpty         = empty;
    assign bus.fifoFull          = full;
    assign bus.numElementsInFifo = 16'(count_q);

endmodule

// File: tb/tb_usb_tx_fifo.sv
// Directed bench for usb_tx_fifo: drivers queue expected read-back and pop data,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_usb_tx_fifo;

    logic usbClk;
    logic rstN;
    logic chk_pop;
    logic rd_pend;
    int   n_cmp;
    int   n_err;

    logic [7:0] exp_q[$];
    logic [7:0] pop_q[$];

    usb_tx_fifo_if bus ();

    usb_tx_fifo dut (
        .usbClk (usbClk),
        .rstN   (rstN),
        .bus    (bus)
    );

    // Clock and reset
    initial begin
        usbClk = 1'b0;
        forever #5 usbClk = ~usbClk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare bus read-back one cycle after the strobe, pop data in the pop cycle
    always @(negedge usbClk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL bus_rd_unexpected: got %h expected none", bus.busDataOut);
            end else begin
                check("bus_rd", 16'(bus.busDataOut), 16'(exp_q.pop_front()));
            end
        end
        rd_pend = rstN & bus.busFifoSelect & bus.busStrobe_i & ~bus.busWriteEn;
        if (chk_pop) begin
            if (pop_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got %h expected none", bus.fifoDataOut);
            end else begin
                check("pop_data", 16'(bus.fifoDataOut), 16'(pop_q.pop_front()));
            end
        end
    end

    // Driver tasks: each call occupies one clock cycle, entered and left at posedge+1
    task automatic cyc(input logic stb, input logic we, input logic [2:0] a, input logic [7:0] d,
                       input logic ren, input logic chk, input logic [7:0] pexp);
        bus.busFifoSelect = stb;
        bus.busStrobe_i   = stb;
        bus.busWriteEn    = we;
        bus.busAddress    = a;
        bus.busDataIn     = d;
        bus.fifoREn       = ren;
        chk_pop           = chk;
        if (chk) pop_q.push_back(pexp);
        @(posedge usbClk);
        #1;
        bus.busFifoSelect = 1'b0;
        bus.busStrobe_i   = 1'b0;
        bus.busWriteEn    = 1'b0;
        bus.busAddress    = 3'd0;
        bus.busDataIn     = 8'h00;
        bus.fifoREn       = 1'b0;
        chk_pop           = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, 1'b1, 3'd0, d, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic pop(input logic [7:0] e);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, e);
    endtask

    task automatic push_pop(input logic [7:0] d, input logic [7:0] e);
        cyc(1'b1, 1'b1, 3'd0, d, 1'b1, 1'b1, e);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b1, a, d, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        cyc(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        chk_pop = 1'b0;
        rd_pend = 1'b0;
        bus.busFifoSelect = 1'b0;
        bus.busStrobe_i   = 1'b0;
        bus.busWriteEn    = 1'b0;
        bus.busAddress    = 3'd0;
        bus.busDataIn     = 8'h00;
        bus.fifoREn       = 1'b0;
        rstN = 1'b0;
        repeat (3) @(posedge usbClk);
        #1;
        rstN = 1'b1;

        // 1. Reset state
        check("rst_empty", 16'(bus.fifoEmpty), 16'd1);
        check("rst_full", 16'(bus.fifoFull), 16'd0);
        check("rst_count", bus.numElementsInFifo, 16'd0);
        check("rst_busdata", 16'(bus.busDataOut), 16'h00);
        rd(3'd1, 8'h01);
        rd(3'd4, 8'h00);

        // 2. Two pushes, two pops
        push(8'hA5);
        check("t2_count1", bus.numElementsInFifo, 16'd1);
        push(8'h3C);
        check("t2_count2", bus.numElementsInFifo, 16'd2);
        check("t2_head", 16'(bus.fifoDataOut), 16'h00A5);
        pop(8'hA5);
        check("t2_count3", bus.numElementsInFifo, 16'd1);
        check("t2_head2", 16'(bus.fifoDataOut), 16'h003C);
        pop(8'h3C);
        check("t2_count4", bus.numElementsInFifo, 16'd0);
        check("t2_empty", 16'(bus.fifoEmpty), 16'd1);

        // 3. Fill, overflow, drain
        for (int i = 0; i < 64; i++) push(8'(i));
        check("t3_full", 16'(bus.fifoFull), 16'd1);
        check("t3_count", bus.numElementsInFifo, 16'd64);
        rd(3'd3, 8'h00);
        rd(3'd4, 8'h40);
        push(8'hFF);
        check("t3_count_ovf", bus.numElementsInFifo, 16'd64);
        rd(3'd1, 8'h06);
        for (int i = 0; i < 64; i++) pop(8'(i));
        check("t3_empty", 16'(bus.fifoEmpty), 16'd1);
        rd(3'd1, 8'h05);
        rd(3'd5, 8'h00);
        wr(3'd2, 8'h01);
        rd(3'd1, 8'h01);

        // 4a. Simultaneous push and pop at count 10
        for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
        check("t4_count10", bus.numElementsInFifo, 16'd10);
        push_pop(8'h77, 8'h10);
        check("t4_count_pp", bus.numElementsInFifo, 16'd10);
        wr(3'd2, 8'h01);
        check("t4_fe_count", bus.numElementsInFifo, 16'd0);

        // 4b. Push+pop while full: push dropped, overflow set
        for (int i = 0; i < 64; i++) push(8'h80 + 8'(i));
        check("t4_full", 16'(bus.fifoFull), 16'd1);
        push_pop(8'hEE, 8'h80);
        check("t4_count63", bus.numElementsInFifo, 16'd63);
        check("t4_notfull", 16'(bus.fifoFull), 16'd0);
        rd(3'd1, 8'h04);
        for (int i = 1; i < 64; i++) pop(8'h80 + 8'(i));
        check("t4_empty", 16'(bus.fifoEmpty), 16'd1);

        // 5. forceEmpty with a same-cycle pop request, overflow sticky beforehand
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        rd(3'd1, 8'h04);
        rd(3'd4, 8'h05);
        cyc(1'b1, 1'b1, 3'd2, 8'h01, 1'b1, 1'b0, 8'h00);
        check("t5_count", bus.numElementsInFifo, 16'd0);
        check("t5_empty", 16'(bus.fifoEmpty), 16'd1);
        check("t5_mem_kept", 16'(bus.fifoDataOut), 16'h0050);
        rd(3'd1, 8'h01);

        // 6a. Asynchronous reset mid-stream
        for (int i = 0; i < 20; i++) push(8'(i));
        check("t6_count20", bus.numElementsInFifo, 16'd20);
        #2;
        rstN = 1'b0;
        #1;
        check("t6_arst_count", bus.numElementsInFifo, 16'd0);
        check("t6_arst_empty", 16'(bus.fifoEmpty), 16'd1);
        check("t6_arst_full", 16'(bus.fifoFull), 16'd0);
        @(posedge usbClk);
        #1;
        rstN = 1'b1;

        // 6b. Pointer wrap with count held at 3
        for (int i = 0; i < 3; i++) push(8'(i));
        for (int k = 0; k < 200; k++) push_pop(8'(k + 3), 8'(k));
        check("t6_wrap_count", bus.numElementsInFifo, 16'd3);
        rd(3'd4, 8'h03);
        for (int k = 200; k < 203; k++) pop(8'(k));
        check("t6_wrap_empty", 16'(bus.fifoEmpty), 16'd1);

        repeat (3) cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (exp_q.size() != 0 || pop_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: got %0d/%0d pending expected 0/0", exp_q.size(), pop_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
